// File: rtl/dcm_clock_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcm_clock_scheduler_pkg
//  Purpose  : Shared types and constants for the DCM multiplier sequencer and
//             the command decoder (state encoding, widths, default limits).
//  Revision : 1.0  initial release
// ============================================================================
package dcm_clock_scheduler_pkg;

    localparam int c_MULT_W = 8;
    localparam int c_CNT_W  = 20;

    localparam logic [c_MULT_W-1:0] c_DEFAULT_MIN_MULT     = 8'd2;
    localparam logic [c_MULT_W-1:0] c_DEFAULT_MAX_MULT     = 8'd64;
    localparam logic [c_MULT_W-1:0] c_DEFAULT_SAFE_MULT    = 8'd8;
    localparam logic [c_MULT_W-1:0] c_DEFAULT_INITIAL_MULT = 8'd16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_SETTLE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dcm_clock_scheduler_multiplier_clamp.sv
`default_nettype none
// ============================================================================
//  Module   : multiplier_clamp
//  Purpose  : Combinational clamp of a raw multiplier into [MIN, MAX] plus the
//             thermal-ceiling select that yields the effective target.
//  Revision : 1.0  initial release
// ============================================================================
module multiplier_clamp
    import dcm_clock_scheduler_pkg::*;
#(
    parameter logic [c_MULT_W-1:0] MIN_MULT  = c_DEFAULT_MIN_MULT,
    parameter logic [c_MULT_W-1:0] MAX_MULT  = c_DEFAULT_MAX_MULT,
    parameter logic [c_MULT_W-1:0] SAFE_MULT = c_DEFAULT_SAFE_MULT
) (
    input  logic [c_MULT_W-1:0] i_raw_mult,
    output logic [c_MULT_W-1:0] o_clamped_mult,
    input  logic [c_MULT_W-1:0] i_target_mult,
    input  logic                i_thermal_alert,
    output logic [c_MULT_W-1:0] o_eff_mult,
    output logic                o_throttle
);

    // Unsigned clamp of the incoming request into the legal range
    always_comb begin
        o_clamped_mult = i_raw_mult;
        if (i_raw_mult < MIN_MULT) begin
            o_clamped_mult = MIN_MULT;
        end else if (i_raw_mult > MAX_MULT) begin
            o_clamped_mult = MAX_MULT;
        end
    end

    // Thermal ceiling only bites when the stored target is above the safe value
    always_comb begin
        o_throttle = i_thermal_alert && (i_target_mult > SAFE_MULT);
        o_eff_mult = o_throttle ? SAFE_MULT : i_target_mult;
    end

endmodule
`default_nettype wire

// File: rtl/dcm_clock_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dcm_clock_scheduler
//  Purpose  : Walks the DCM multiplier toward the effective target through a
//             req/ack handshake: single-step ramps up with a settle interval,
//             single jump down; sticky error on programmer ack timeout.
//  Revision : 1.0  initial release
// ============================================================================
module dcm_clock_scheduler
    import dcm_clock_scheduler_pkg::*;
#(
    parameter int MAXIMUM_MULTIPLIER = 64,
    parameter int MINIMUM_MULTIPLIER = 2,
    parameter int INITIAL_MULTIPLIER = 16,
    parameter int SAFE_MULTIPLIER    = 8,
    parameter int STEP_INTERVAL      = 1024,
    parameter int ACK_TIMEOUT        = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                target_valid,
    input  logic [c_MULT_W-1:0] target_mult,
    input  logic                thermal_alert,
    output logic                prog_req,
    output logic [c_MULT_W-1:0] prog_mult,
    input  logic                prog_ack,
    output logic [c_MULT_W-1:0] current_mult,
    output logic                busy,
    output logic                throttled,
    output logic                prog_error
);

    localparam logic [c_MULT_W-1:0] c_MAX_MULT  = c_MULT_W'(MAXIMUM_MULTIPLIER);
    localparam logic [c_MULT_W-1:0] c_MIN_MULT  = c_MULT_W'(MINIMUM_MULTIPLIER);
    localparam logic [c_MULT_W-1:0] c_INIT_MULT = c_MULT_W'(INITIAL_MULTIPLIER);
    localparam logic [c_MULT_W-1:0] c_SAFE_MULT = c_MULT_W'(SAFE_MULTIPLIER);
    localparam logic [c_CNT_W-1:0]  c_STEP_LAST = c_CNT_W'(STEP_INTERVAL - 1);
    localparam logic [c_CNT_W-1:0]  c_ACK_LAST  = c_CNT_W'(ACK_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_MULT_W-1:0] r_target;
    logic [c_MULT_W-1:0] r_current;
    logic [c_MULT_W-1:0] r_prog_mult;
    logic                r_prog_req;
    logic                r_up_step;
    logic                r_throttled;
    logic                r_error;
    logic [c_CNT_W-1:0]  r_interval_cnt;
    logic [c_CNT_W-1:0]  r_timeout_cnt;

    logic [c_MULT_W-1:0] w_clamped;
    logic [c_MULT_W-1:0] w_eff;
    logic                w_throttle;
    logic                w_is_up;
    logic [c_MULT_W-1:0] w_step_mult;
    logic                w_decide;
    logic                w_ack_done;
    logic                w_timeout;

    multiplier_clamp #(
        .MIN_MULT  (c_MIN_MULT),
        .MAX_MULT  (c_MAX_MULT),
        .SAFE_MULT (c_SAFE_MULT)
    ) u_clamp (
        .i_raw_mult      (target_mult),
        .o_clamped_mult  (w_clamped),
        .i_target_mult   (r_target),
        .i_thermal_alert (thermal_alert),
        .o_eff_mult      (w_eff),
        .o_throttle      (w_throttle)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and step decision; unknown current (0) or a lower target jumps
    always_comb begin
        w_state_next = r_state;
        w_decide     = 1'b0;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        w_is_up      = (r_current != '0) && (w_eff > r_current);
        w_step_mult  = w_is_up ? (r_current + 8'd1) : w_eff;
        case (r_state)
            ST_IDLE: begin
                if (w_eff != r_current) begin
                    w_decide     = 1'b1;
                    w_state_next = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                w_state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (prog_ack) begin
                    w_ack_done   = 1'b1;
                    w_state_next = r_up_step ? ST_SETTLE : ST_IDLE;
                end else if (r_timeout_cnt >= c_ACK_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if ((w_eff < r_current) || (r_interval_cnt >= c_STEP_LAST)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Target latch, throttle flag, request value and handshake bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_target    <= c_INIT_MULT;
            r_current   <= '0;
            r_prog_mult <= '0;
            r_prog_req  <= 1'b0;
            r_up_step   <= 1'b0;
            r_throttled <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_throttled <= w_throttle;
            if (target_valid) begin
                r_target <= w_clamped;
            end
            if (w_decide) begin
                r_prog_mult <= w_step_mult;
                r_up_step   <= w_is_up;
            end
            if (r_state == ST_REQUEST) begin
                r_prog_req <= 1'b1;
            end
            if (w_ack_done) begin
                r_prog_req <= 1'b0;
                r_current  <= r_prog_mult;
            end
            if (w_timeout) begin
                r_prog_req <= 1'b0;
                r_error    <= 1'b1;
                r_current  <= '0;
            end
        end
    end

    // Ack timeout counter: cleared on issue, saturating while waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_cnt <= '0;
        end else if (r_state == ST_REQUEST) begin
            r_timeout_cnt <= '0;
        end else if ((r_state == ST_WAIT_ACK) && (r_timeout_cnt != '1)) begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
        end
    end

    // Settle interval counter: cleared on ack, saturating while settling
    always_ff @(posedge clk) begin
        if (reset) begin
            r_interval_cnt <= '0;
        end else if (w_ack_done) begin
            r_interval_cnt <= '0;
        end else if ((r_state == ST_SETTLE) && (r_interval_cnt != '1)) begin
            r_interval_cnt <= r_interval_cnt + 1'b1;
        end
    end

    assign prog_req     = r_prog_req;
    assign prog_mult    = r_prog_mult;
    assign current_mult = r_current;
    assign busy         = (r_state != ST_IDLE);
    assign throttled    = r_throttled;
    assign prog_error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_dcm_clock_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcm_clock_scheduler
//  Purpose  : Scenario bench for the DCM sequencer with a randomised-latency
//             programmer responder and a request-sequence reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcm_clock_scheduler;

    localparam int c_STEP    = 4;
    localparam int c_TIMEOUT = 16;
    localparam int c_SAFE    = 8;

    logic       clk;
    logic       reset;
    logic       target_valid;
    logic [7:0] target_mult;
    logic       thermal_alert;
    logic       prog_req;
    logic [7:0] prog_mult;
    logic       prog_ack;
    logic [7:0] current_mult;
    logic       busy;
    logic       throttled;
    logic       prog_error;

    int errors;
    int checks;
    int cyc;

    // programmer responder controls
    bit ack_enable;
    int ack_min;
    int ack_max;
    int ack_d;
    int ack_cnt;

    // request log filled by the monitor
    logic [7:0] log_val[$];
    int         log_rise[$];
    int         log_fall[$];
    logic       mon_prev;
    logic [7:0] mon_hold;

    // reference model state
    int         m_target;
    int         m_current;
    bit         m_thermal;
    logic [7:0] exp_q[$];

    dcm_clock_scheduler #(
        .STEP_INTERVAL (c_STEP),
        .ACK_TIMEOUT   (c_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .target_valid  (target_valid),
        .target_mult   (target_mult),
        .thermal_alert (thermal_alert),
        .prog_req      (prog_req),
        .prog_mult     (prog_mult),
        .prog_ack      (prog_ack),
        .current_mult  (current_mult),
        .busy          (busy),
        .throttled     (throttled),
        .prog_error    (prog_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Programmer model: acks each request after a random delay, drops out on reset
    initial begin
        prog_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (prog_req === 1'b1 && ack_enable) begin
                ack_d   = $urandom_range(ack_max, ack_min);
                ack_cnt = 1;
                while (prog_req === 1'b1 && ack_cnt < ack_d) begin
                    @(posedge clk); #1;
                    ack_cnt++;
                end
                if (prog_req === 1'b1) begin
                    prog_ack = 1'b1;
                    @(posedge clk); #1;
                    prog_ack = 1'b0;
                end
                while (prog_req === 1'b1) begin
                    @(posedge clk); #1;
                end
            end
        end
    end

    // Monitor: records every request and checks prog_mult holds while requested
    initial begin
        mon_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (prog_req === 1'b1 && mon_prev !== 1'b1) begin
                log_val.push_back(prog_mult);
                log_rise.push_back(cyc);
                mon_hold = prog_mult;
            end else if (prog_req === 1'b1) begin
                checks++;
                if (prog_mult !== mon_hold) begin
                    errors++;
                    $display("FAIL prog_mult_stable: got %0d want %0d at cycle %0d", prog_mult, mon_hold, cyc);
                end
            end
            if (prog_req !== 1'b1 && mon_prev === 1'b1) log_fall.push_back(cyc);
            mon_prev = prog_req;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic int f_clamp(int v);
        return (v < 2) ? 2 : ((v > 64) ? 64 : v);
    endfunction

    function automatic int f_eff();
        return (m_thermal && m_target > c_SAFE) ? c_SAFE : m_target;
    endfunction

    // Reference: list of programmed values needed to reach the effective target
    task automatic plan_moves();
        int nxt;
        while (f_eff() != m_current) begin
            nxt = (m_current == 0 || f_eff() < m_current) ? f_eff() : m_current + 1;
            exp_q.push_back(8'(nxt));
            m_current = nxt;
        end
    endtask

    task automatic clear_logs();
        log_val.delete();
        log_rise.delete();
        log_fall.delete();
        exp_q.delete();
    endtask

    task automatic pulse_target(input int v);
        @(posedge clk); #1;
        target_mult  = 8'(v);
        target_valid = 1'b1;
        @(posedge clk); #1;
        target_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(posedge clk); #1;
            quiet = (busy === 1'b0 && prog_req === 1'b0) ? quiet + 1 : 0;
            n++;
        end
        checks++;
        if (quiet < 3) begin
            errors++;
            $display("FAIL %s_quiet: still busy after %0d cycles (busy=%b req=%b)", name, budget, busy, prog_req);
        end
    endtask

    task automatic wait_req(input logic level, input int budget, input string name);
        int n = 0;
        while (prog_req !== level && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (prog_req !== level) begin
            errors++;
            $display("FAIL %s_wait_req: prog_req=%b want %b within %0d cycles", name, prog_req, level, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({prog_req, busy, throttled, prog_error} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: req/busy/thr/err=%b want 0000", {prog_req, busy, throttled, prog_error});
        end
        checks++;
        if ({prog_mult, current_mult} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_values: prog_mult=%0d current_mult=%0d want 0 0", prog_mult, current_mult);
        end
        clear_logs();
        m_target = 16; m_current = 0; m_thermal = 0;
        plan_moves();
        reset = 1'b0;
        wait_quiet(200, "reset");
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (log_val.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_req_count: got %0d want %0d", log_val.size(), exp_q.size());
        end
        for (int i = 0; i < log_val.size() && i < exp_q.size(); i++) begin
            checks++;
            if (log_val[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_req[%0d]: got %0d want %0d", i, log_val[i], exp_q[i]);
            end
        end
        checks++;
        if (current_mult !== 8'(m_current) || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_settled: current=%0d busy=%b want %0d 0", current_mult, busy, m_current);
        end
    endtask

    task automatic test_ramp_up();
        clear_logs();
        pulse_target(20);
        m_target = f_clamp(20);
        plan_moves();
        wait_quiet(500, "ramp");
        checks++;
        if (log_val.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ramp_req_count: got %0d want %0d", log_val.size(), exp_q.size());
        end
        for (int i = 0; i < log_val.size() && i < exp_q.size(); i++) begin
            checks++;
            if (log_val[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ramp_req[%0d]: got %0d want %0d", i, log_val[i], exp_q[i]);
            end
        end
        for (int i = 1; i < log_rise.size() && i <= log_fall.size(); i++) begin
            checks++;
            if (log_rise[i] - log_fall[i-1] < c_STEP) begin
                errors++;
                $display("FAIL ramp_settle_gap[%0d]: got %0d cycles want >= %0d", i, log_rise[i] - log_fall[i-1], c_STEP);
            end
        end
        checks++;
        if (current_mult !== 8'(m_current)) begin
            errors++;
            $display("FAIL ramp_current: got %0d want %0d", current_mult, m_current);
        end
    endtask

    task automatic test_thermal();
        int t;
        t = 20 + $urandom_range(6, 3);
        clear_logs();
        pulse_target(t);
        m_target = t;
        exp_q.push_back(8'(m_current + 1));
        wait_req(1'b1, 50, "thermal_up");
        wait_req(1'b0, 50, "thermal_up_ack");
        thermal_alert = 1'b1;
        m_current = m_current + 1;
        m_thermal = 1;
        plan_moves();
        wait_quiet(200, "thermal_down");
        checks++;
        if (log_val.size() != exp_q.size()) begin
            errors++;
            $display("FAIL thermal_req_count: got %0d want %0d", log_val.size(), exp_q.size());
        end
        for (int i = 0; i < log_val.size() && i < exp_q.size(); i++) begin
            checks++;
            if (log_val[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL thermal_req[%0d]: got %0d want %0d", i, log_val[i], exp_q[i]);
            end
        end
        if (log_rise.size() > 1 && log_fall.size() > 0) begin
            checks++;
            if (log_rise[1] - log_fall[0] >= c_STEP) begin
                errors++;
                $display("FAIL thermal_abort_settle: got gap %0d cycles want < %0d", log_rise[1] - log_fall[0], c_STEP);
            end
        end
        checks++;
        if (throttled !== 1'b1 || current_mult !== 8'(m_current)) begin
            errors++;
            $display("FAIL thermal_hold: throttled=%b current=%0d want 1 %0d", throttled, current_mult, m_current);
        end
        clear_logs();
        thermal_alert = 1'b0;
        m_thermal = 0;
        plan_moves();
        wait_quiet(1000, "thermal_release");
        checks++;
        if (log_val.size() != exp_q.size()) begin
            errors++;
            $display("FAIL release_req_count: got %0d want %0d", log_val.size(), exp_q.size());
        end
        for (int i = 0; i < log_val.size() && i < exp_q.size(); i++) begin
            checks++;
            if (log_val[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL release_req[%0d]: got %0d want %0d", i, log_val[i], exp_q[i]);
            end
        end
        checks++;
        if (throttled !== 1'b0 || current_mult !== 8'(m_current)) begin
            errors++;
            $display("FAIL release_final: throttled=%b current=%0d want 0 %0d", throttled, current_mult, m_current);
        end
    endtask

    task automatic test_clamp();
        int vals[6];
        vals[0] = 200;
        vals[1] = 0;
        vals[2] = 1;
        for (int k = 3; k < 6; k++) vals[k] = $urandom_range(255, 0);
        for (int k = 0; k < 6; k++) begin
            clear_logs();
            pulse_target(vals[k]);
            m_target = f_clamp(vals[k]);
            plan_moves();
            repeat (3) @(posedge clk);
            wait_quiet(2000, "clamp");
            checks++;
            if (log_val.size() != exp_q.size()) begin
                errors++;
                $display("FAIL clamp_req_count(%0d): got %0d want %0d", vals[k], log_val.size(), exp_q.size());
            end
            for (int i = 0; i < log_val.size() && i < exp_q.size(); i++) begin
                checks++;
                if (log_val[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL clamp_req(%0d)[%0d]: got %0d want %0d", vals[k], i, log_val[i], exp_q[i]);
                end
            end
            checks++;
            if (current_mult !== 8'(m_current)) begin
                errors++;
                $display("FAIL clamp_current(%0d): got %0d want %0d", vals[k], current_mult, m_current);
            end
        end
    endtask

    task automatic test_timeout();
        int t;
        int first;
        t = f_clamp($urandom_range(64, 2));
        if (t == m_current) t = (m_current == 64) ? 63 : m_current + 1;
        clear_logs();
        ack_enable = 1'b0;
        pulse_target(t);
        m_target = t;
        first = (f_eff() < m_current) ? f_eff() : m_current + 1;
        exp_q.push_back(8'(first));
        wait_req(1'b1, 50, "timeout_issue");
        wait_req(1'b0, c_TIMEOUT + 10, "timeout_drop");
        checks++;
        if (prog_error !== 1'b1 || current_mult !== 8'd0) begin
            errors++;
            $display("FAIL timeout_flag: prog_error=%b current=%0d want 1 0", prog_error, current_mult);
        end
        ack_enable = 1'b1;
        m_current = 0;
        plan_moves();
        wait_quiet(200, "timeout_retry");
        checks++;
        if (log_val.size() != exp_q.size()) begin
            errors++;
            $display("FAIL timeout_req_count: got %0d want %0d", log_val.size(), exp_q.size());
        end
        for (int i = 0; i < log_val.size() && i < exp_q.size(); i++) begin
            checks++;
            if (log_val[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL timeout_req[%0d]: got %0d want %0d", i, log_val[i], exp_q[i]);
            end
        end
        if (log_fall.size() > 0 && log_rise.size() > 0) begin
            checks++;
            if (log_fall[0] - log_rise[0] != c_TIMEOUT) begin
                errors++;
                $display("FAIL timeout_duration: got %0d cycles want %0d", log_fall[0] - log_rise[0], c_TIMEOUT);
            end
        end
        checks++;
        if (prog_error !== 1'b1 || current_mult !== 8'(m_current)) begin
            errors++;
            $display("FAIL timeout_sticky: prog_error=%b current=%0d want 1 %0d", prog_error, current_mult, m_current);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        t = (m_current < 60) ? m_current + 2 : m_current - 5;
        clear_logs();
        ack_min = 10;
        ack_max = 10;
        pulse_target(t);
        wait_req(1'b1, 50, "midreset_issue");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (prog_req !== 1'b0) begin
            errors++;
            $display("FAIL midreset_req_drop: prog_req=%b want 0", prog_req);
        end
        checks++;
        if ({busy, throttled, prog_error, prog_mult, current_mult} !== 19'h0) begin
            errors++;
            $display("FAIL midreset_values: busy=%b thr=%b err=%b prog_mult=%0d current=%0d want all 0", busy, throttled, prog_error, prog_mult, current_mult);
        end
        reset = 1'b0;
        ack_min = 1;
        ack_max = 6;
        clear_logs();
        m_target = 16; m_current = 0; m_thermal = 0;
        plan_moves();
        wait_quiet(200, "midreset_restart");
        checks++;
        if (log_val.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midreset_req_count: got %0d want %0d", log_val.size(), exp_q.size());
        end
        for (int i = 0; i < log_val.size() && i < exp_q.size(); i++) begin
            checks++;
            if (log_val[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset_req[%0d]: got %0d want %0d", i, log_val[i], exp_q[i]);
            end
        end
        checks++;
        if (current_mult !== 8'(m_current) || prog_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_final: current=%0d err=%b want %0d 0", current_mult, prog_error, m_current);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        cyc           = 0;
        reset         = 1'b1;
        target_valid  = 1'b0;
        target_mult   = 8'd0;
        thermal_alert = 1'b0;
        ack_enable    = 1'b1;
        ack_min       = 1;
        ack_max       = 6;
        test_reset();
        test_ramp_up();
        test_thermal();
        test_clamp();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
